// File: rtl/tmr_mon_pkg.sv
// ============================================================================
// tmr_mon_pkg : shared types, defaults and saturating helper for TMR monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package tmr_mon_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int SAT_W         = 64;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } snap_state_t;

  // Operates on a wide container so one function serves any counter width <= 63.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int bits);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << bits) - SAT_W'(1);
    return (val >= max_val) ? max_val : val + SAT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmr_maj3.sv
// ============================================================================
// tmr_maj3 : combinational bitwise 2-of-3 majority
// Rev 1.0
// ============================================================================
`default_nettype none

module tmr_maj3
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj
);

  assign maj = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/tmr_vote_monitor.sv
// ============================================================================
// tmr_vote_monitor : majority voter with per-lane upset counters and snapshot
// Rev 1.0
// ============================================================================
`default_nettype none

module tmr_vote_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clkA,
  input  logic                 rstA,
  input  logic                 enA,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic [WIDTH-1:0]     inC,
  output logic [WIDTH-1:0]     voted,
  output logic                 errA,
  output logic                 errB,
  output logic                 errC,
  output logic                 err_multi,
  input  logic                 snap_req,
  input  logic                 snap_ack,
  output logic                 snap_valid,
  output logic [CNT_WIDTH-1:0] snap_cntA,
  output logic [CNT_WIDTH-1:0] snap_cntB,
  output logic [CNT_WIDTH-1:0] snap_cntC
);

  localparam int C_LANES = 3;

  logic [WIDTH-1:0]     w_maj;
  logic [WIDTH-1:0]     w_lane [C_LANES];
  logic [C_LANES-1:0]   w_mis;
  logic                 w_capture;
  logic [WIDTH-1:0]     r_voted;
  logic [C_LANES-1:0]   r_err;
  logic                 r_err_multi;
  logic [CNT_WIDTH-1:0] r_cnt  [C_LANES];
  logic [CNT_WIDTH-1:0] r_snap [C_LANES];
  snap_state_t          r_state;
  logic                 r_snap_valid;

  tmr_maj3 #(.WIDTH(WIDTH)) u_maj (
    .a   (inA),
    .b   (inB),
    .c   (inC),
    .maj (w_maj)
  );

  assign w_lane[0] = inA;
  assign w_lane[1] = inB;
  assign w_lane[2] = inC;
  assign w_capture = (r_state == ST_IDLE) && snap_req;

  always_ff @(posedge clkA or posedge rstA) begin
    if (rstA) begin
      r_voted     <= '0;
      r_err_multi <= 1'b0;
    end else begin
      r_voted     <= w_maj;
      r_err_multi <= (w_mis[0] & w_mis[1]) | (w_mis[0] & w_mis[2]) | (w_mis[1] & w_mis[2]);
    end
  end

  for (genvar l = 0; l < C_LANES; l++) begin : g_lane
    assign w_mis[l] = enA && (w_lane[l] != w_maj);

    // On capture the new window starts at this cycle's mismatch so no upset is lost.
    always_ff @(posedge clkA or posedge rstA) begin
      if (rstA) begin
        r_err[l]  <= 1'b0;
        r_cnt[l]  <= '0;
        r_snap[l] <= '0;
      end else begin
        r_err[l] <= w_mis[l];
        if (w_capture) begin
          r_snap[l] <= r_cnt[l];
          r_cnt[l]  <= CNT_WIDTH'(w_mis[l]);
        end else if (w_mis[l]) begin
          r_cnt[l]  <= CNT_WIDTH'(sat_inc(SAT_W'(r_cnt[l]), CNT_WIDTH));
        end
      end
    end
  end

  always_ff @(posedge clkA or posedge rstA) begin
    if (rstA) begin
      r_state      <= ST_IDLE;
      r_snap_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (snap_req) begin
            r_state      <= ST_HOLD;
            r_snap_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (snap_ack) begin
            r_state      <= ST_IDLE;
            r_snap_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_snap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign voted      = r_voted;
  assign errA       = r_err[0];
  assign errB       = r_err[1];
  assign errC       = r_err[2];
  assign err_multi  = r_err_multi;
  assign snap_valid = r_snap_valid;
  assign snap_cntA  = r_snap[0];
  assign snap_cntB  = r_snap[1];
  assign snap_cntC  = r_snap[2];

endmodule

`default_nettype wire

// File: tb/tb_tmr_vote_monitor.sv
// ============================================================================
// tb_tmr_vote_monitor : directed stimulus, behavioural model and literal checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tmr_vote_monitor;

  logic       clkA, rstA, enA, snap_req, snap_ack;
  logic [7:0] inA, inB, inC;

  logic [7:0]  voted, voted4;
  logic        errA, errB, errC, err_multi;
  logic        errA4, errB4, errC4, err_multi4;
  logic        snap_valid, snap_valid4;
  logic [15:0] snap_cntA, snap_cntB, snap_cntC;
  logic [3:0]  snap4A, snap4B, snap4C;

  int checks   = 0;
  int failures = 0;

  tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(16)) dut16 (
    .clkA(clkA), .rstA(rstA), .enA(enA), .inA(inA), .inB(inB), .inC(inC),
    .voted(voted), .errA(errA), .errB(errB), .errC(errC), .err_multi(err_multi),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid),
    .snap_cntA(snap_cntA), .snap_cntB(snap_cntB), .snap_cntC(snap_cntC)
  );

  tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clkA(clkA), .rstA(rstA), .enA(enA), .inA(inA), .inB(inB), .inC(inC),
    .voted(voted4), .errA(errA4), .errB(errB4), .errC(errC4), .err_multi(err_multi4),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid4),
    .snap_cntA(snap4A), .snap_cntB(snap4B), .snap_cntC(snap4C)
  );

  initial clkA = 1'b0;
  always #5 clkA = ~clkA;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: integer counts clipped at the counter ceiling, snapshot as a plain copy.
  logic [7:0]  m_voted;
  bit          m_err [3];
  bit          m_multi, m_hold;
  int unsigned m_cnt16 [3], m_cnt4 [3], m_snap16 [3], m_snap4 [3];

  always @(posedge clkA or posedge rstA) begin
    logic [7:0] ins [3];
    logic [7:0] maj;
    bit         mis [3];
    int         nmis;
    if (rstA) begin
      m_voted = '0; m_multi = 0; m_hold = 0;
      for (int l = 0; l < 3; l++) begin
        m_err[l] = 0; m_cnt16[l] = 0; m_cnt4[l] = 0; m_snap16[l] = 0; m_snap4[l] = 0;
      end
    end else begin
      ins[0] = inA; ins[1] = inB; ins[2] = inC;
      for (int b = 0; b < 8; b++)
        maj[b] = ((int'(inA[b]) + int'(inB[b]) + int'(inC[b])) >= 2);
      nmis = 0;
      for (int l = 0; l < 3; l++) begin
        mis[l] = enA && (ins[l] != maj);
        nmis += int'(mis[l]);
        m_err[l] = mis[l];
      end
      m_voted = maj;
      m_multi = (nmis >= 2);
      if (!m_hold && snap_req) begin
        m_hold = 1;
        for (int l = 0; l < 3; l++) begin
          m_snap16[l] = m_cnt16[l]; m_snap4[l] = m_cnt4[l];
          m_cnt16[l] = int'(mis[l]); m_cnt4[l] = int'(mis[l]);
        end
      end else begin
        if (m_hold && snap_ack) m_hold = 0;
        for (int l = 0; l < 3; l++) if (mis[l]) begin
          if (m_cnt16[l] < 65535) m_cnt16[l]++;
          if (m_cnt4[l] < 15) m_cnt4[l]++;
        end
      end
    end
  end

  always @(negedge clkA) begin
    if (!rstA) begin
      chk("voted", voted, m_voted);
      chk("voted4", voted4, m_voted);
      chk("errA", errA, m_err[0]);
      chk("errB", errB, m_err[1]);
      chk("errC", errC, m_err[2]);
      chk("err_multi", err_multi, m_multi);
      chk("err4", {errA4, errB4, errC4, err_multi4}, {m_err[0], m_err[1], m_err[2], m_multi});
      chk("snap_valid", snap_valid, m_hold);
      chk("snap_valid4", snap_valid4, m_hold);
      chk("snap_cntA", snap_cntA, m_snap16[0]);
      chk("snap_cntB", snap_cntB, m_snap16[1]);
      chk("snap_cntC", snap_cntC, m_snap16[2]);
      chk("snap4A", snap4A, m_snap4[0]);
      chk("snap4B", snap4B, m_snap4[1]);
      chk("snap4C", snap4C, m_snap4[2]);
    end
  end

  // Inputs change at a negedge; returns at the following negedge with outputs settled.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic en, input logic req, input logic ack);
    inA = a; inB = b; inC = c; enA = en; snap_req = req; snap_ack = ack;
    @(negedge clkA);
  endtask

  initial begin
    rstA = 1'b1; enA = 0; snap_req = 0; snap_ack = 0; inA = 0; inB = 0; inC = 0;
    repeat (2) @(negedge clkA);
    chk("rst_voted", voted, 8'h00);
    chk("rst_valid", snap_valid, 1'b0);
    chk("rst_err", {errA, errB, errC, err_multi}, 4'h0);
    rstA = 1'b0;

    step(8'h5A, 8'h5A, 8'h5A, 1, 0, 0);
    chk("t1_voted", voted, 8'h5A);
    chk("t1_err", {errA, errB, errC, err_multi}, 4'h0);

    repeat (3) begin
      step(8'h5B, 8'h5A, 8'h5A, 1, 0, 0);
      chk("t2_errA", errA, 1'b1);
    end
    step(8'h5A, 8'h5A, 8'h5A, 1, 1, 0);
    chk("t2_valid", snap_valid, 1'b1);
    chk("t2_cntA", snap_cntA, 16'd3);
    chk("t2_cntBC", {snap_cntB, snap_cntC}, 32'd0);
    step(8'h5A, 8'h5A, 8'h5A, 1, 0, 1);
    chk("t2_ack", snap_valid, 1'b0);

    step(8'h01, 8'h02, 8'h00, 1, 0, 0);
    chk("t3_voted", voted, 8'h00);
    chk("t3_flags", {errA, errB, errC, err_multi}, 4'b1101);

    step(8'h00, 8'h00, 8'h00, 1, 1, 0);
    step(8'h00, 8'h00, 8'h00, 1, 0, 1);
    repeat (5) step(8'h00, 8'h00, 8'hFF, 1, 0, 0);
    step(8'h00, 8'h00, 8'hFF, 1, 1, 0);
    chk("t4_cntC", snap_cntC, 16'd5);
    step(8'h00, 8'h00, 8'h00, 1, 0, 1);
    step(8'h00, 8'h00, 8'h00, 1, 1, 0);
    chk("t4_cntC_next", snap_cntC, 16'd1);
    step(8'h00, 8'h00, 8'h00, 1, 0, 1);

    repeat (20) step(8'h00, 8'hFF, 8'h00, 1, 0, 0);
    repeat (3) begin
      step(8'h00, 8'hFF, 8'h00, 0, 0, 0);
      chk("en0_errB", errB, 1'b0);
    end
    step(8'h00, 8'h00, 8'h00, 1, 1, 0);
    chk("t5_sat4", snap4B, 4'hF);
    chk("t5_cnt16", snap_cntB, 16'd20);

    step(8'h00, 8'hFF, 8'h00, 1, 1, 0);
    chk("t6_req_ign_valid", snap_valid, 1'b1);
    chk("t6_req_ign_cnt", snap_cntB, 16'd20);
    step(8'h00, 8'h00, 8'h00, 1, 1, 1);
    chk("t6_both_valid", snap_valid, 1'b0);
    chk("t6_both_cnt", snap_cntB, 16'd20);
    step(8'h00, 8'h00, 8'h00, 1, 1, 0);
    chk("t6_recap", snap_cntB, 16'd1);
    snap_req = 0;
    #3 rstA = 1'b1;
    #1;
    chk("t6_rst_valid", snap_valid, 1'b0);
    chk("t6_rst_cnt", {snap_cntA, snap_cntB, snap_cntC}, 48'd0);
    @(negedge clkA);
    rstA = 1'b0;
    step(8'h33, 8'h33, 8'h33, 1, 0, 0);
    chk("post_rst_voted", voted, 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
